spio_uart_rx_control: RTL

// Receive-side control for the SpiNNaker-over-UART link. Accepts the decoded byte stream from the

---
 rtl/spio_uart_rx_control_pkg.sv | 24 ++
 rtl/spio_uart_rx_control_sync_detect.sv | 45 ++++
 rtl/spio_uart_rx_control.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spio_uart_rx_control_pkg.sv
// ---------------------------------------------------------------------------
// spio_uart_rx_control_pkg
// Shared constants and types for the SpiNNaker-over-UART receive controller.
// The packet lengths and sync byte values are also used by the transmit
// controller, so they live here rather than in either module.
// ---------------------------------------------------------------------------
package spio_uart_rx_control_pkg;

    localparam int PKT_LEN  = 72;   // long packet: 9 bytes
    localparam int SPKT_LEN = 40;   // short packet: 5 bytes

    localparam logic [7:0] UART_SYNC_NULL = 8'h00;
    localparam logic [7:0] UART_SYNC_END  = 8'hFF;

    localparam logic [3:0] CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        RX_RESET  = 2'd0,
        RX_UNSYNC = 2'd1,
        RX_RECV   = 2'd2,
        RX_DONE   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/spio_uart_rx_control_sync_detect.sv
// ---------------------------------------------------------------------------
// spio_uart_rx_sync_detect
// Counts consecutive accepted null bytes (saturating at 15) and flags an
// accepted end-of-sync byte that follows a long enough run of nulls.
//
// Ports:
//   CLK_IN, RESET_IN   clock, async active-high reset
//   byte_in            byte currently offered
//   accept_in          byte is being transferred this cycle
//   sync_hit_out       comb: this accepted byte completes a sync sequence
// ---------------------------------------------------------------------------
module spio_uart_rx_sync_detect
    import spio_uart_rx_control_pkg::*;
#(
    parameter logic [3:0] NULLS_REQUIRED = 4'd12
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic [7:0] byte_in,
    input  logic       accept_in,
    output logic       sync_hit_out
);

    logic [3:0] null_cnt_q, null_cnt_d;

    always_comb begin
        null_cnt_d = null_cnt_q;
        if (accept_in) begin
            if (byte_in == UART_SYNC_NULL) begin
                if (null_cnt_q != CNT_MAX) null_cnt_d = null_cnt_q + 4'd1;
            end else begin
                null_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) null_cnt_q <= 4'd0;
        else          null_cnt_q <= null_cnt_d;
    end

    assign sync_hit_out = accept_in && (byte_in == UART_SYNC_END) &&
                          (null_cnt_q >= NULLS_REQUIRED);

endmodule

// File: rtl/spio_uart_rx_control.sv
// ---------------------------------------------------------------------------
// spio_uart_rx_control
// Receive-side control for the SpiNNaker-over-UART link. Locks onto the
// null-run + 0xFF sync sequence, reassembles head-first short (5-byte) or
// long (9-byte) packets, checks odd parity and hands good packets on.
//
// Ports:
//   CLK_IN, RESET_IN                 clock, async active-high reset
//   BYTE_DATA_IN/VLD_IN/RDY_OUT      byte stream from the deserialiser
//   PKT_DATA_OUT/VLD_OUT/RDY_IN      packet stream to the router side
//   PKT_DROPPED_OUT                  pulse: completed packet failed parity
//   SYNC_SEEN_OUT                    pulse: sync sequence detected
//   SYNCHRONISED_OUT                 level: locked to the byte stream
// ---------------------------------------------------------------------------
module spio_uart_rx_control
    import spio_uart_rx_control_pkg::*;
#(
    parameter logic [3:0] NULLS_REQUIRED  = 4'd12,
    parameter logic [3:0] DROPS_TO_UNSYNC = 4'd4
) (
    input  logic               CLK_IN,
    input  logic               RESET_IN,
    input  logic [7:0]         BYTE_DATA_IN,
    input  logic               BYTE_VLD_IN,
    output logic               BYTE_RDY_OUT,
    output logic [PKT_LEN-1:0] PKT_DATA_OUT,
    output logic               PKT_VLD_OUT,
    input  logic               PKT_RDY_IN,
    output logic               PKT_DROPPED_OUT,
    output logic               SYNC_SEEN_OUT,
    output logic               SYNCHRONISED_OUT
);

    rx_state_t          state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [PKT_LEN-1:0] pkt_q, pkt_d;
    logic               is_long_q, is_long_d;
    logic               all_zero_q, all_zero_d;
    logic [3:0]         drop_cnt_q, drop_cnt_d;
    logic               dropped_q, dropped_d;
    logic               sync_seen_q, sync_seen_d;
    logic               synced_q, synced_d;

    logic               accept, sync_hit;
    logic [PKT_LEN-1:0] pkt_wr;
    logic               is_long_now, all_zero_now, last_byte, parity_ok;

    // Handshake outputs come straight from registered state.
    assign BYTE_RDY_OUT     = (state_q == RX_UNSYNC) || (state_q == RX_RECV);
    assign PKT_VLD_OUT      = (state_q == RX_DONE);
    assign PKT_DATA_OUT     = pkt_q;
    assign PKT_DROPPED_OUT  = dropped_q;
    assign SYNC_SEEN_OUT    = sync_seen_q;
    assign SYNCHRONISED_OUT = synced_q;

    assign accept = BYTE_VLD_IN && BYTE_RDY_OUT;

    spio_uart_rx_sync_detect #(
        .NULLS_REQUIRED (NULLS_REQUIRED)
    ) u_sync_detect (
        .CLK_IN       (CLK_IN),
        .RESET_IN     (RESET_IN),
        .byte_in      (BYTE_DATA_IN),
        .accept_in    (accept),
        .sync_hit_out (sync_hit)
    );

    // Packet image with the incoming byte merged in, so parity and the
    // all-zero test include the final byte of the packet.
    always_comb begin
        pkt_wr = (idx_q == 4'd0) ? '0 : pkt_q;
        for (int k = 0; k < 9; k++) begin
            if (idx_q == k[3:0]) pkt_wr[8*k +: 8] = BYTE_DATA_IN;
        end
        is_long_now  = (idx_q == 4'd0) ? BYTE_DATA_IN[1] : is_long_q;
        all_zero_now = (BYTE_DATA_IN == UART_SYNC_NULL) && ((idx_q == 4'd0) || all_zero_q);
        last_byte    = (idx_q == 4'd8) || ((idx_q == 4'd4) && !is_long_q);
        // Short packets have bits above SPKT_LEN cleared, but keep the
        // reduction explicit to match the packet format.
        parity_ok    = is_long_q ? (^pkt_wr) : (^pkt_wr[SPKT_LEN-1:0]);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pkt_d       = pkt_q;
        is_long_d   = is_long_q;
        all_zero_d  = all_zero_q;
        drop_cnt_d  = drop_cnt_q;
        dropped_d   = 1'b0;
        sync_seen_d = 1'b0;
        synced_d    = synced_q;

        case (state_q)
            RX_RESET: state_d = RX_UNSYNC;

            RX_UNSYNC, RX_RECV: begin
                if (accept) begin
                    // Sync wins over completion; any partial packet is dropped silently.
                    if (sync_hit) begin
                        state_d     = RX_RECV;
                        idx_d       = 4'd0;
                        sync_seen_d = 1'b1;
                        synced_d    = 1'b1;
                        drop_cnt_d  = 4'd0;
                    end else if (state_q == RX_RECV) begin
                        pkt_d      = pkt_wr;
                        is_long_d  = is_long_now;
                        all_zero_d = all_zero_now;
                        idx_d      = idx_q + 4'd1;
                        if (last_byte) begin
                            idx_d = 4'd0;
                            // An all-zero packet is just sync nulls framed as data.
                            if (!all_zero_now) begin
                                if (parity_ok) begin
                                    state_d    = RX_DONE;
                                    drop_cnt_d = 4'd0;
                                end else begin
                                    dropped_d  = 1'b1;
                                    if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 4'd1;
                                    if ((DROPS_TO_UNSYNC != 4'd0) && (drop_cnt_d == DROPS_TO_UNSYNC)) begin
                                        state_d  = RX_UNSYNC;
                                        synced_d = 1'b0;
                                    end
                                end
                            end
                        end
                    end
                end
            end

            RX_DONE: begin
                if (PKT_RDY_IN) begin
                    state_d = RX_RECV;
                    idx_d   = 4'd0;
                end
            end

            default: state_d = RX_RESET;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q     <= RX_RESET;
            idx_q       <= 4'd0;
            is_long_q   <= 1'b0;
            all_zero_q  <= 1'b0;
            drop_cnt_q  <= 4'd0;
            dropped_q   <= 1'b0;
            sync_seen_q <= 1'b0;
            synced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            is_long_q   <= is_long_d;
            all_zero_q  <= all_zero_d;
            drop_cnt_q  <= drop_cnt_d;
            dropped_q   <= dropped_d;
            sync_seen_q <= sync_seen_d;
            synced_q    <= synced_d;
        end
    end

    // Packet payload carries no reset value; it is only meaningful in DONE.
    always_ff @(posedge CLK_IN) begin
        pkt_q <= pkt_d;
    end

endmodule
